// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel runtime-programmable clock divider (toggle / pulse output).
// Define CLK_DIV_BANK_PHASE_SYNC_EN to add a sync input that realigns every channel.

module clk_div_chan #(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_DIV  = 5,
    parameter int DEFAULT_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_mode,
    output logic             pending,
    output logic             out,
    output logic             tick
);
    logic [CNT_W-1:0] cnt, d_act, d_sh;
    logic             mode, mode_sh;
    logic             evt, apply;

    assign evt   = en && !sync && (cnt == d_act);
    // Shadow values only move to the live set at a period boundary or while idle,
    // so the output never sees a truncated half-period.
    assign apply = pending && (sync || !en || evt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            d_act   <= CNT_W'(DEFAULT_DIV);
            d_sh    <= CNT_W'(DEFAULT_DIV);
            mode    <= (DEFAULT_MODE != 0);
            mode_sh <= (DEFAULT_MODE != 0);
            pending <= 1'b0;
            out     <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (wr) begin
                d_sh    <= wr_div;
                mode_sh <= wr_mode;
            end
            // A write in the apply cycle re-arms pending for the following boundary.
            if (wr)
                pending <= 1'b1;
            else if (apply)
                pending <= 1'b0;
            if (apply) begin
                d_act <= d_sh;
                mode  <= mode_sh;
            end
            if (sync || !en) begin
                cnt  <= '0;
                out  <= 1'b0;
                tick <= 1'b0;
            end else if (evt) begin
                cnt  <= '0;
                tick <= 1'b1;
                if (apply && (mode_sh != mode))
                    out <= 1'b0;
                else if (mode)
                    out <= 1'b1;
                else
                    out <= ~out;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
                if (mode)
                    out <= 1'b0;
            end
        end
    end
endmodule

module clk_div_bank #(
    parameter int CHANNELS     = 2,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_DIV  = 5,
    parameter int DEFAULT_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic                div_wr,
    input  logic [2:0]          div_sel,
    input  logic [CNT_W-1:0]    div_data,
    input  logic                div_mode,
`ifdef CLK_DIV_BANK_PHASE_SYNC_EN
    input  logic                sync,
`endif
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] tick
);
    logic sync_all;

`ifdef CLK_DIV_BANK_PHASE_SYNC_EN
    assign sync_all = sync;
`else
    assign sync_all = 1'b0;
`endif

    // Out-of-range selects match no channel, so such writes fall away.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic wr_ch;
        assign wr_ch = div_wr && (div_sel == 3'(i));

        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .DEFAULT_MODE(DEFAULT_MODE)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .en     (en[i]),
            .sync   (sync_all),
            .wr     (wr_ch),
            .wr_div (div_data),
            .wr_mode(div_mode),
            .pending(pending[i]),
            .out    (out[i]),
            .tick   (tick[i])
        );
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: directed scenarios then random traffic, against a
// timestamp-based reference model (absolute cycle of each channel's next boundary).

module tb_clk_div_bank;
    localparam int CH = 2;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] en;
    logic          div_wr;
    logic [2:0]    div_sel;
    logic [W-1:0]  div_data;
    logic          div_mode;
    logic [CH-1:0] pending, out, tick;
    logic          syn_m;
`ifdef CLK_DIV_BANK_PHASE_SYNC_EN
    logic          sync;
`endif

    int checks = 0;
    int errors = 0;
    int cy = 0;

    // reference model state
    int m_d[CH], m_sd[CH], m_nxt[CH];
    bit m_mode[CH], m_smode[CH], m_pend[CH], m_run[CH], m_out[CH], m_tick[CH];

    always #5 clk = ~clk;

    clk_div_bank #(.CHANNELS(CH), .CNT_W(W), .DEFAULT_DIV(5), .DEFAULT_MODE(0)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .div_wr  (div_wr),
        .div_sel (div_sel),
        .div_data(div_data),
        .div_mode(div_mode),
`ifdef CLK_DIV_BANK_PHASE_SYNC_EN
        .sync    (sync),
`endif
        .pending (pending),
        .out     (out),
        .tick    (tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cy);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < CH; i++) begin
            m_d[i] = 5; m_sd[i] = 5; m_nxt[i] = 0;
            m_mode[i] = 0; m_smode[i] = 0; m_pend[i] = 0;
            m_run[i] = 0; m_out[i] = 0; m_tick[i] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic m_step(input bit syn);
        cy++;
        for (int i = 0; i < CH; i++) begin
            bit w, ev, ap;
            w  = div_wr && (int'(div_sel) == i);
            ev = 0;
            if (!en[i] || syn) begin
                m_run[i] = 0; m_out[i] = 0; m_tick[i] = 0;
                ap = m_pend[i];
            end else begin
                if (!m_run[i]) begin
                    m_run[i] = 1;
                    m_nxt[i] = cy + m_d[i];
                end
                ev = (cy == m_nxt[i]);
                ap = m_pend[i] && ev;
                m_tick[i] = ev;
                if (ev) begin
                    if (ap && (m_smode[i] != m_mode[i])) m_out[i] = 0;
                    else if (m_mode[i])                  m_out[i] = 1;
                    else                                 m_out[i] = !m_out[i];
                end else if (m_mode[i]) begin
                    m_out[i] = 0;
                end
            end
            if (ap) begin
                m_d[i] = m_sd[i]; m_mode[i] = m_smode[i];
            end
            if (ev) m_nxt[i] = cy + m_d[i] + 1;
            if (w) begin
                m_sd[i] = int'(div_data); m_smode[i] = div_mode; m_pend[i] = 1;
            end else if (ap) begin
                m_pend[i] = 0;
            end
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            logic [CH-1:0] eo, et, ep;
`ifdef CLK_DIV_BANK_PHASE_SYNC_EN
            syn_m = sync;
`else
            syn_m = 1'b0;
`endif
            m_step(syn_m);
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < CH; i++) begin
                eo[i] = m_out[i]; et[i] = m_tick[i]; ep[i] = m_pend[i];
            end
            chk("out", 32'(out), 32'(eo));
            chk("tick", 32'(tick), 32'(et));
            chk("pending", 32'(pending), 32'(ep));
        end
    endtask

    task automatic wr(input int sel, input int d, input bit md);
        div_wr = 1'b1; div_sel = 3'(sel); div_data = W'(d); div_mode = md;
        cyc(1);
        div_wr = 1'b0;
    endtask

    task automatic wait_tick0(input string tag);
        bit ok = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            if (tick[0]) begin ok = 1; break; end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int n;
        bit ok;
        reset = 1'b1; en = '0; div_wr = 1'b0; div_sel = '0; div_data = '0; div_mode = 1'b0;
`ifdef CLK_DIV_BANK_PHASE_SYNC_EN
        sync = 1'b0;
`endif
        m_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        reset = 1'b0;

        // 1: defaults, ch0 toggles with 6-cycle halves
        en = 2'b01;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (out[0]) begin ok = 1; break; end
        end
        chk("t1_rise", 32'(ok), 32'd1);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (out[0]) n++; else break;
        end
        chk("t1_high", 32'(n), 32'd6);
        cyc(24);

        // 2: program idle ch1 as pulse D=3, applied next cycle
        wr(1, 3, 1'b1);
        chk("t2_pend_set", 32'(pending[1]), 32'd1);
        cyc(1);
        chk("t2_pend_clr", 32'(pending[1]), 32'd0);
        en = 2'b11;
        cyc(20);

        // 3: retarget ch0 to D=1 while cnt=2
        wait_tick0("t3_sync");
        cyc(1);
        wr(0, 1, 1'b0);
        chk("t3_pend_held", 32'(pending[0]), 32'd1);
        cyc(20);

        // 4: double write then out-of-range write; only last in-range value lands
        wr(0, 7, 1'b0);
        cyc(12);
        wait_tick0("t4_sync");
        wr(0, 9, 1'b0);
        wr(0, 2, 1'b0);
        wr(5, 7, 1'b1);
        chk("t4_pend", 32'(pending), 32'b01);
        cyc(24);

        // 5: async reset while a write is pending
        wr(0, 11, 1'b1);
        chk("t5_pend", 32'(pending[0]), 32'd1);
        cyc(1);
        reset = 1'b1;
        #1;
        chk("t5_out", 32'(out), 32'd0);
        chk("t5_tick", 32'(tick), 32'd0);
        chk("t5_pend0", 32'(pending), 32'd0);
        m_reset();
        en = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        en = 2'b01;
        n = 0; ok = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(1); n++;
            if (tick[0]) begin ok = 1; break; end
        end
        chk("t5_first_tick", 32'(n), 32'd6);
        cyc(14);

`ifdef CLK_DIV_BANK_PHASE_SYNC_EN
        // 6: phase sync of D=1 and D=3 toggle channels
        en = 2'b11;
        wr(0, 1, 1'b0);
        wr(1, 3, 1'b0);
        cyc(20);
        sync = 1'b1;
        cyc(1);
        sync = 1'b0;
        chk("t6_out0", 32'(out), 32'd0);
        for (int k = 0; k < 32; k++) begin
            logic [CH-1:0] prev;
            prev = out;
            cyc(1);
            if (out[1] != prev[1]) chk("t6_align", 32'(out[0] != prev[0]), 32'd1);
        end
`endif

        // random traffic
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(15) == 0) en[$urandom_range(CH-1)] ^= 1'b1;
            div_wr = ($urandom_range(7) == 0);
            div_sel = 3'($urandom_range(7) < 6 ? $urandom_range(CH-1) : $urandom_range(7));
            div_data = W'($urandom_range(6));
            div_mode = 1'($urandom_range(1));
`ifdef CLK_DIV_BANK_PHASE_SYNC_EN
            sync = ($urandom_range(63) == 0);
`endif
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
